// File: rtl/trigger_burst_pkg.sv
// Shared types and default widths for the trigger burst sequencer.
// The optional watchdog is enabled with TRIGGER_BURST_TIMEOUT_EN.
package trigger_burst_pkg;

  localparam int TRIGGER_COUNTER_WIDTH_DEF = 32;
  localparam int BURST_WIDTH_DEF           = 16;
  localparam int SOURCE_WIDTH_DEF          = 5;
  localparam int WATCHDOG_WIDTH            = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_ARM,
    ST_WAIT_ARMED,
    ST_RUN,
    ST_DONE,
    ST_ERROR
  } state_t;

  // States in which the watchdog is allowed to run.
  function automatic logic is_watched(input state_t s);
    return (s == ST_WAIT_ARMED) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/trigger_period_check.sv
// Registered |last - reference| > tolerance compare for the burst sequencer.
// The FSM samples the registered result on the trigger edge strobe.
module trigger_period_check #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic [W-1:0] i_last_counter,
  input  logic [W-1:0] i_reference,
  input  logic [W-1:0] i_tolerance,
  output logic         o_out_of_tol
);

  logic signed [W:0] w_diff;
  logic        [W:0] w_abs;
  logic              r_out_of_tol;

  // One extra bit keeps the signed difference of two unsigned values exact.
  assign w_diff = $signed({1'b0, i_last_counter}) - $signed({1'b0, i_reference});
  assign w_abs  = w_diff[W] ? $unsigned(-w_diff) : $unsigned(w_diff);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_out_of_tol <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // flop samples pre-edge values regardless of block ordering.
      r_out_of_tol <= (w_abs > {1'b0, i_tolerance});
    end
  end

  assign o_out_of_tol = r_out_of_tol;

endmodule

// File: rtl/trigger_burst_sequencer.sv
// Burst acquisition sequencer driving the counter-based delayed trigger.
// Define TRIGGER_BURST_TIMEOUT_EN to build the WAIT_ARMED/RUN watchdog.
module trigger_burst_sequencer
  import trigger_burst_pkg::*;
#(
  parameter int TRIGGER_COUNTER_WIDTH = TRIGGER_COUNTER_WIDTH_DEF,
  parameter int BURST_WIDTH           = BURST_WIDTH_DEF,
  parameter int SOURCE_WIDTH          = SOURCE_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             aresetn,
  input  logic                             start,
  input  logic                             abort,
  input  logic [BURST_WIDTH-1:0]           burst_count,
  input  logic [SOURCE_WIDTH-1:0]          source_cfg,
  input  logic [TRIGGER_COUNTER_WIDTH-1:0] reference_counter,
  input  logic [TRIGGER_COUNTER_WIDTH-1:0] period_tolerance,
  input  logic [WATCHDOG_WIDTH-1:0]        timeout_cycles,
  input  logic                             cdt_trigger,
  input  logic                             cdt_armed_status,
  input  logic [TRIGGER_COUNTER_WIDTH-1:0] cdt_last_counter,
  output logic                             cdt_enable,
  output logic                             cdt_arm,
  output logic                             cdt_trigger_reset,
  output logic [SOURCE_WIDTH-1:0]          cdt_source_select,
  output logic                             busy,
  output logic                             done,
  output logic                             period_error,
  output logic                             timeout_flag,
  output logic                             acq_gate,
  output logic [BURST_WIDTH-1:0]           trigger_count
);

  state_t                   r_state;
  logic                     r_trig_q;
  logic                     r_enable;
  logic                     r_arm;
  logic                     r_trigger_reset;
  logic [SOURCE_WIDTH-1:0]  r_source;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_period_error;
  logic                     r_timeout_flag;
  logic                     r_acq_gate;
  logic [BURST_WIDTH-1:0]   r_count;

  logic                     w_trig_edge;
  logic                     w_first_edge;
  logic [BURST_WIDTH-1:0]   w_count_inc;
  logic                     w_complete;
  logic                     w_period_bad;
  logic                     w_timeout_hit;

  assign w_trig_edge  = cdt_trigger & ~r_trig_q;
  assign w_first_edge = (r_count == '0);
  assign w_count_inc  = (r_count == '1) ? r_count : r_count + BURST_WIDTH'(1);
  assign w_complete   = (burst_count != '0) && (w_count_inc == burst_count);

  trigger_period_check #(
    .W (TRIGGER_COUNTER_WIDTH)
  ) u_period_check (
    .clk            (clk),
    .aresetn        (aresetn),
    .i_last_counter (cdt_last_counter),
    .i_reference    (reference_counter),
    .i_tolerance    (period_tolerance),
    .o_out_of_tol   (w_period_bad)
  );

`ifdef TRIGGER_BURST_TIMEOUT_EN
  logic [WATCHDOG_WIDTH-1:0] r_wdog;

  // Held at zero outside WAIT_ARMED/RUN, so every entry starts from zero.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_wdog <= '0;
    end else if (abort || !is_watched(r_state)) begin
      r_wdog <= '0;
    end else if ((r_state == ST_WAIT_ARMED && cdt_armed_status) ||
                 (r_state == ST_RUN && w_trig_edge)) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + WATCHDOG_WIDTH'(1);
    end
  end

  assign w_timeout_hit = (timeout_cycles != '0) && (r_wdog == timeout_cycles);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^timeout_cycles;
  assign w_timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state         <= ST_IDLE;
      r_trig_q        <= 1'b0;
      r_enable        <= 1'b0;
      r_arm           <= 1'b0;
      r_trigger_reset <= 1'b0;
      r_source        <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_period_error  <= 1'b0;
      r_timeout_flag  <= 1'b0;
      r_acq_gate      <= 1'b0;
      r_count         <= '0;
    end else begin
      r_trig_q        <= cdt_trigger;
      // Arm and trigger-reset are single-cycle pulses; default them low.
      r_arm           <= 1'b0;
      r_trigger_reset <= 1'b0;

      if (abort) begin
        r_state    <= ST_IDLE;
        r_enable   <= 1'b0;
        r_busy     <= 1'b0;
        r_acq_gate <= 1'b0;
        r_done     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
              r_state         <= ST_RESET;
              r_source        <= source_cfg;
              r_count         <= '0;
              r_done          <= 1'b0;
              r_period_error  <= 1'b0;
              r_timeout_flag  <= 1'b0;
              r_trigger_reset <= 1'b1;
              r_enable        <= 1'b1;
              r_busy          <= 1'b1;
            end
          end

          ST_RESET: begin
            r_state <= ST_ARM;
            r_arm   <= 1'b1;
          end

          ST_ARM: begin
            r_state <= ST_WAIT_ARMED;
          end

          ST_WAIT_ARMED: begin
            if (cdt_armed_status) begin
              r_state <= ST_RUN;
            end else if (w_timeout_hit) begin
              r_state        <= ST_ERROR;
              r_timeout_flag <= 1'b1;
              r_enable       <= 1'b0;
              r_busy         <= 1'b0;
            end
          end

          ST_RUN: begin
            if (w_trig_edge) begin
              r_count <= w_count_inc;
              // A bad period wins over completion on the same edge.
              if (!w_first_edge && w_period_bad) begin
                r_state        <= ST_ERROR;
                r_period_error <= 1'b1;
                r_acq_gate     <= 1'b0;
                r_enable       <= 1'b0;
                r_busy         <= 1'b0;
              end else if (w_complete) begin
                r_state    <= ST_DONE;
                r_done     <= 1'b1;
                r_acq_gate <= 1'b0;
                r_enable   <= 1'b0;
                r_busy     <= 1'b0;
              end else begin
                r_acq_gate <= 1'b1;
              end
            end else if (w_timeout_hit) begin
              r_state        <= ST_ERROR;
              r_timeout_flag <= 1'b1;
              r_acq_gate     <= 1'b0;
              r_enable       <= 1'b0;
              r_busy         <= 1'b0;
            end
          end

          default: begin
            r_state  <= ST_IDLE;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cdt_enable        = r_enable;
  assign cdt_arm           = r_arm;
  assign cdt_trigger_reset = r_trigger_reset;
  assign cdt_source_select = r_source;
  assign busy              = r_busy;
  assign done              = r_done;
  assign period_error      = r_period_error;
  assign timeout_flag      = r_timeout_flag;
  assign acq_gate          = r_acq_gate;
  assign trigger_count     = r_count;

endmodule

// File: tb/tb_trigger_burst_sequencer.sv
// Scoreboard bench for trigger_burst_sequencer; burst width reduced so the
// continuous-mode saturation is reachable quickly.
module tb_trigger_burst_sequencer;

  localparam int CW = 32;
  localparam int BW = 8;
  localparam int SW = 5;

  logic          clk;
  logic          aresetn;
  logic          start;
  logic          abort;
  logic [BW-1:0] burst_count;
  logic [SW-1:0] source_cfg;
  logic [CW-1:0] reference_counter;
  logic [CW-1:0] period_tolerance;
  logic [31:0]   timeout_cycles;
  logic          cdt_trigger;
  logic          cdt_armed_status;
  logic [CW-1:0] cdt_last_counter;
  logic          cdt_enable;
  logic          cdt_arm;
  logic          cdt_trigger_reset;
  logic [SW-1:0] cdt_source_select;
  logic          busy;
  logic          done;
  logic          period_error;
  logic          timeout_flag;
  logic          acq_gate;
  logic [BW-1:0] trigger_count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string         tag;
    logic [BW-1:0] count;
    logic          gate;
    logic          dn;
    logic          perr;
    logic          bsy;
    logic          en;
  } exp_t;

  exp_t sb_q[$];

  trigger_burst_sequencer #(
    .TRIGGER_COUNTER_WIDTH (CW),
    .BURST_WIDTH           (BW),
    .SOURCE_WIDTH          (SW)
  ) dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .start             (start),
    .abort             (abort),
    .burst_count       (burst_count),
    .source_cfg        (source_cfg),
    .reference_counter (reference_counter),
    .period_tolerance  (period_tolerance),
    .timeout_cycles    (timeout_cycles),
    .cdt_trigger       (cdt_trigger),
    .cdt_armed_status  (cdt_armed_status),
    .cdt_last_counter  (cdt_last_counter),
    .cdt_enable        (cdt_enable),
    .cdt_arm           (cdt_arm),
    .cdt_trigger_reset (cdt_trigger_reset),
    .cdt_source_select (cdt_source_select),
    .busy              (busy),
    .done              (done),
    .period_error      (period_error),
    .timeout_flag      (timeout_flag),
    .acq_gate          (acq_gate),
    .trigger_count     (trigger_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "bench time limit expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input int cnt, input bit gate,
                              input bit dn, input bit perr, input bit bsy, input bit en);
    exp_t e;
    e.tag   = tag;
    e.count = BW'(cnt);
    e.gate  = gate;
    e.dn    = dn;
    e.perr  = perr;
    e.bsy   = bsy;
    e.en    = en;
    return e;
  endfunction

  task automatic compare_next();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 64'(sb_q.size()), 64'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, ".count"}, trigger_count, e.count);
      check({e.tag, ".gate"},  acq_gate,      e.gate);
      check({e.tag, ".done"},  done,          e.dn);
      check({e.tag, ".perr"},  period_error,  e.perr);
      check({e.tag, ".busy"},  busy,          e.bsy);
      check({e.tag, ".en"},    cdt_enable,    e.en);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One trigger rising edge; expectation is queued with the stimulus and
  // compared one edge later. The trigger stays high for 1+hold cycles.
  task automatic fire(input logic [CW-1:0] last, input int gap, input int hold, input exp_t e);
    cdt_last_counter = last;
    repeat (gap) tick();
    cdt_trigger = 1'b1;
    sb_q.push_back(e);
    tick();
    compare_next();
    repeat (hold) tick();
    cdt_trigger = 1'b0;
    tick();
  endtask

  task automatic do_start(input logic [SW-1:0] src);
    source_cfg = src;
    start = 1'b1;
    tick();
    start = 1'b0;
    source_cfg = ~src;
    check("start.trig_reset", cdt_trigger_reset, 1'b1);
    check("start.arm_early",  cdt_arm,           1'b0);
    check("start.busy",       busy,              1'b1);
    check("start.enable",     cdt_enable,        1'b1);
    check("start.source",     cdt_source_select, src);
    check("start.count_clr",  trigger_count,     '0);
    check("start.done_clr",   done,              1'b0);
    check("start.perr_clr",   period_error,      1'b0);
    check("start.tflag_clr",  timeout_flag,      1'b0);
    tick();
    check("start.arm",         cdt_arm,           1'b1);
    check("start.trig_reset2", cdt_trigger_reset, 1'b0);
    tick();
    check("start.arm_done",    cdt_arm,           1'b0);
    check("start.wait_busy",   busy,              1'b1);
  endtask

  task automatic arm_and_run();
    cdt_armed_status = 1'b1;
    tick();
    check("run.busy", busy, 1'b1);
    check("run.gate", acq_gate, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".enable"}, cdt_enable,        1'b0);
    check({tag, ".arm"},    cdt_arm,           1'b0);
    check({tag, ".trst"},   cdt_trigger_reset, 1'b0);
    check({tag, ".src"},    cdt_source_select, '0);
    check({tag, ".busy"},   busy,              1'b0);
    check({tag, ".done"},   done,              1'b0);
    check({tag, ".perr"},   period_error,      1'b0);
    check({tag, ".tflag"},  timeout_flag,      1'b0);
    check({tag, ".gate"},   acq_gate,          1'b0);
    check({tag, ".count"},  trigger_count,     '0);
  endtask

  initial begin
    aresetn           = 1'b0;
    start             = 1'b0;
    abort             = 1'b0;
    burst_count       = BW'(3);
    source_cfg        = 5'h1F;
    reference_counter = 32'd250;
    period_tolerance  = 32'd5;
    timeout_cycles    = 32'd0;
    cdt_trigger       = 1'b0;
    cdt_armed_status  = 1'b0;
    cdt_last_counter  = 32'd250;

    repeat (3) tick();
    check_all_zero("reset");
    aresetn = 1'b1;
    repeat (6) tick();
    check("idle.busy", busy, 1'b0);
    check("idle.src",  cdt_source_select, '0);

    // Start sequence, then triggers while the trigger is not yet armed.
    do_start(5'h13);
    for (int i = 0; i < 10; i++) begin
      cdt_trigger = 1'b1;
      tick();
      cdt_trigger = 1'b0;
      tick();
    end
    check("unarmed.count", trigger_count, '0);
    check("unarmed.busy",  busy, 1'b1);
    check("unarmed.gate",  acq_gate, 1'b0);
    arm_and_run();

    // Nominal burst of 3; the first period is not checked, the last is d == tol.
    fire(32'd999, 248, 0, mk("nom1", 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    fire(32'd253, 248, 4, mk("nom2", 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    check("nom.held_once", trigger_count, BW'(2));
    fire(32'd245, 248, 0, mk("nom3", 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

    // Period error: second period 256 -> d = 6 > 5.
    burst_count = BW'(5);
    do_start(5'h07);
    arm_and_run();
    fire(32'd250, 248, 0, mk("perr1", 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    fire(32'd256, 248, 0, mk("perr2", 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    fire(32'd250, 10,  0, mk("perr_term", 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_err.perr_kept",  period_error, 1'b1);
    check("abort_err.count_kept", trigger_count, BW'(2));
    check("abort_err.busy",       busy, 1'b0);

    // Period error on the completing edge goes to ERROR, not DONE.
    burst_count = BW'(2);
    do_start(5'h02);
    arm_and_run();
    fire(32'd250, 20, 0, mk("cerr1", 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    fire(32'd200, 20, 0, mk("cerr2", 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));

    // Abort coincident with the second edge: the edge is not counted.
    burst_count = BW'(4);
    do_start(5'h0A);
    arm_and_run();
    fire(32'd250, 20, 0, mk("ab1", 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    repeat (20) tick();
    cdt_trigger = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab2.count", trigger_count, BW'(1));
    check("ab2.gate",  acq_gate, 1'b0);
    check("ab2.busy",  busy, 1'b0);
    check("ab2.en",    cdt_enable, 1'b0);
    cdt_trigger = 1'b0;
    tick();
    fire(32'd250, 5, 0, mk("ab_idle", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Single-trigger burst to DONE, then start and abort together.
    burst_count = BW'(1);
    do_start(5'h11);
    arm_and_run();
    fire(32'd777, 20, 0, mk("one", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa.trst",  cdt_trigger_reset, 1'b0);
    check("sa.busy",  busy, 1'b0);
    check("sa.done",  done, 1'b0);
    check("sa.count", trigger_count, BW'(1));
    tick();
    check("sa.arm",   cdt_arm, 1'b0);

    // Watchdog: no triggers after RUN entry.
    timeout_cycles = 32'd1000;
    burst_count = BW'(3);
    do_start(5'h05);
    arm_and_run();
    repeat (1000) tick();
    check("wd.flag_early", timeout_flag, 1'b0);
    check("wd.busy_early", busy, 1'b1);
    tick();
`ifdef TRIGGER_BURST_TIMEOUT_EN
    check("wd.flag", timeout_flag, 1'b1);
    check("wd.busy", busy, 1'b0);
    check("wd.en",   cdt_enable, 1'b0);
`else
    check("wd.flag_off", timeout_flag, 1'b0);
    check("wd.busy_off", busy, 1'b1);
`endif
    abort = 1'b1;
    tick();
    abort = 1'b0;
    timeout_cycles = 32'd0;

    // Continuous mode saturates the count and never completes.
    burst_count = '0;
    cdt_last_counter = 32'd250;
    do_start(5'h1C);
    arm_and_run();
    sb_q.push_back(mk("cont", (1 << BW) - 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    for (int i = 0; i < 300; i++) begin
      cdt_trigger = 1'b1;
      tick();
      cdt_trigger = 1'b0;
      tick();
    end
    compare_next();

    // Asynchronous reset mid-burst, away from any clock edge.
    #2;
    aresetn = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    aresetn = 1'b1;
    tick();
    check("post_rst.busy", busy, 1'b0);

    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trigger_burst_sequencer.md
# trigger_burst_sequencer

Control-plane sequencer for the counter-based delayed trigger. It owns the delayed trigger's `enable`, `arm`, `trigger_reset` and `source_select` inputs and runs a burst acquisition:

- clear the trigger, arm it, wait until it reports armed, then count a programmed number of trigger pulses;
- check each measured period against the reference period;
- gate the ADC acquisition window while the burst runs.

It sits between the PS register bank and the delayed-trigger instance.

## Interface
- `TRIGGER_COUNTER_WIDTH`, 32, width of the period counter and reference/tolerance values
- `BURST_WIDTH`, 16, width of burst count and trigger count
- `SOURCE_WIDTH`, 5, width of the trigger source select
- `clk`  in  1  acquisition clock; all logic on the rising edge
- `aresetn`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse; begins a burst when idle/done/error
- `abort`  in  1  one-cycle pulse; returns to IDLE from any state
- `burst_count`  in  BURST_WIDTH  triggers per burst; 0 = continuous
- `source_cfg`  in  SOURCE_WIDTH  source forwarded to the trigger, latched on `start`
- `reference_counter`  in  TRIGGER_COUNTER_WIDTH  expected period in clocks
- `period_tolerance`  in  TRIGGER_COUNTER_WIDTH  allowed absolute period deviation
- `timeout_cycles`  in  32  watchdog limit; 0 = disabled
- `cdt_trigger`  in  1  trigger output of the delayed trigger
- `cdt_armed_status`  in  1  armed flag of the delayed trigger
- `cdt_last_counter`  in  TRIGGER_COUNTER_WIDTH  last measured period
- `cdt_enable`  out  1  enable to the delayed trigger
- `cdt_arm`  out  1  one-cycle arm pulse
- `cdt_trigger_reset`  out  1  one-cycle trigger reset pulse
- `cdt_source_select`  out  SOURCE_WIDTH  latched source select
- `busy`  out  1  high in RESET, ARM, WAIT_ARMED, RUN
- `done`  out  1  sticky; burst completed
- `period_error`  out  1  sticky; period out of tolerance
- `timeout_flag`  out  1  sticky; watchdog expired
- `acq_gate`  out  1  acquisition window
- `trigger_count`  out  BURST_WIDTH  triggers seen in the current burst

## Operation
States and transitions:
- **IDLE:** waits for `start`.
- **RESET:** drives `cdt_trigger_reset`=1.
- **ARM:** drives `cdt_arm`=1.
- **WAIT_ARMED:** waits for `cdt_armed_status`=1, then goes to RUN.
- **RUN:** counts triggers.
- **DONE / ERROR:** terminal until the next `start` or `abort`.

Rules:
- **Start:** on `start` in IDLE, DONE or ERROR:
  - latch `source_cfg`;
  - clear `trigger_count`, `done`, `period_error`, `timeout_flag`;
  - go to RESET.
  - `start` is ignored in busy states.
- **Enable:** `cdt_enable`=1 in RESET through RUN, 0 otherwise.
- **Trigger edge:** a rising edge of `cdt_trigger` is detected against a registered copy. Each edge in RUN:
  - increments `trigger_count`;
  - sets `acq_gate` on the first edge.
- **Period check:** applies from the second edge on; the first edge is not checked. Compute `d = |cdt_last_counter − reference_counter|` using a (TRIGGER_COUNTER_WIDTH+1)-bit signed difference.
  - `d > period_tolerance` → ERROR, `period_error`=1.
  - `d == period_tolerance` passes.
- **Completion:** when the incremented count equals a nonzero `burst_count` → DONE, `done`=1, `acq_gate`=0.
- **Continuous mode:** with `burst_count`=0, RUN never completes; `trigger_count` saturates at all-ones.
- **ERROR:** `acq_gate`=0 and `cdt_enable`=0.
- **Abort:** `abort` in any state → IDLE.
  - Clears `acq_gate`, `done` and all `cdt_*` pulses.
  - Error flags and `trigger_count` keep their values.
  - `abort` wins over a simultaneous `start`.
- **Simultaneous events:**
  - A trigger edge in the same cycle as `abort` is not counted.
  - A period error on the completing edge → ERROR, not DONE.

## Timing
- All outputs are registered.
- **Reset values:** state IDLE; every output 0, including `cdt_source_select`.
- `start` at cycle n:
  - `cdt_trigger_reset`=1 at n+1 only;
  - `cdt_arm`=1 at n+2 only;
  - WAIT_ARMED from n+3.
- `cdt_armed_status` sampled high at cycle m → RUN at m+1.
- `cdt_trigger` rising at cycle k (first high sample) → `trigger_count`, `acq_gate`, `done` and `period_error` update at k+1.
- A trigger held high counts once.
- `aresetn` low mid-burst returns everything to reset values immediately (asynchronous).

## Configuration
- **`TRIGGER_BURST_TIMEOUT_EN` defined:** a 32-bit watchdog is active.
  - It is cleared on entry to WAIT_ARMED or RUN, and on every counted edge.
  - It increments in WAIT_ARMED and RUN.
  - Reaching `timeout_cycles` (nonzero) → ERROR, `timeout_flag`=1 one cycle later.
- **Not defined:** no watchdog logic; `timeout_cycles` is ignored and `timeout_flag` is tied to 0. The port list is unchanged.

## Structure
- **Package `trigger_burst_pkg`:** state enumeration (IDLE, RESET, ARM, WAIT_ARMED, RUN, DONE, ERROR) and default widths.
- **Sub-module `trigger_period_check`:** computes the absolute difference and the out-of-tolerance compare, registered with one-cycle latency aligned to the edge strobe. The FSM consumes its result on the edge-plus-one cycle.

## Test plan
- **Nominal burst:** `burst_count`=3, reference=250, tolerance=5, triggers every 250 clocks → count 1,2,3; `done`=1; `acq_gate` high from edge 1 until edge 3 +1 cycle.
- **Period error:** 2nd period = 256 (d=6), tolerance=5 → `period_error`=1 at edge+1, state ERROR, `cdt_enable`=0. Separately, d=5 → passes.
- **Start sequence:** `start` at cycle 10 → `cdt_trigger_reset` at 11, `cdt_arm` at 12. Hold `cdt_armed_status`=0 for 20 cycles → no count despite triggers.
- **Abort:** `abort` with 2nd edge in RUN → count stays 1, IDLE; a simultaneous `start`+`abort` from DONE → IDLE.
- **Continuous mode:** `burst_count`=0 with 70000 edges → `trigger_count`=16'hFFFF, `done`=0.
- **Timeout** (`TRIGGER_BURST_TIMEOUT_EN`): `timeout_cycles`=1000, no triggers → `timeout_flag`=1 about 1001 cycles after RUN entry. Mid-burst `aresetn`=0 → all outputs 0.
